// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared opcode encoding and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int OP_CODE_LEN = 4;

    localparam logic [OP_CODE_LEN-1:0] OP_ADD = 4'h0;
    localparam logic [OP_CODE_LEN-1:0] OP_SUB = 4'h1;
    localparam logic [OP_CODE_LEN-1:0] OP_MUL = 4'h8;
    localparam logic [OP_CODE_LEN-1:0] OP_DIV = 4'h9;
    localparam logic [OP_CODE_LEN-1:0] OP_MOD = 4'hA;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_BUSY = c_st_busy,
        ST_DONE = c_st_done
    } state_t;

    function automatic logic is_muldiv_op(input logic [OP_CODE_LEN-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Iterative shift-add multiply / restoring divide datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_rem,
    output logic [WIDTH-1:0] shift_x
);

    // r_acc: product / remainder; r_x: multiplicand / dividend->quotient;
    // r_y: multiplier / divisor
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_q_bit;

    assign w_rem_sh   = {r_acc, r_x[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_y};
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_y});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (load) begin
            r_acc <= '0;
            r_x   <= a;
            r_y   <= b;
        end else if (step) begin
            if (is_mul) begin
                r_acc <= r_acc + (r_y[0] ? r_x : '0);
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_acc <= w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                r_x   <= {r_x[WIDTH-2:0], w_q_bit};
            end
        end
    end

    assign acc_rem = r_acc;
    assign shift_x = r_x;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : EX-stage MUL/DIV/MOD sequencer with pipeline stall control.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int OP_CODE_LEN = muldiv_pkg::OP_CODE_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [OP_CODE_LEN-1:0] op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   flush,
    output logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   div_by_zero
);

    localparam int             c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [c_cnt_w-1:0]       r_count;
    logic [OP_CODE_LEN-1:0]   r_op;
    logic                     r_dbz;
    logic [WIDTH-1:0]         r_result;

    logic                     w_req;
    logic                     w_req_dbz;
    logic                     w_load;
    logic                     w_step;
    logic [WIDTH-1:0]         w_acc_rem;
    logic [WIDTH-1:0]         w_shift_x;
    logic [WIDTH-1:0]         w_final;

    assign w_req     = start && is_muldiv_op(op);
    assign w_req_dbz = (op != OP_MUL) && (b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = w_req;
                if (w_req && !flush) begin
                    w_load = 1'b1;
                    w_next = w_req_dbz ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_count == c_last) w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = !flush;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_op     <= '0;
            r_dbz    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_load) begin
                r_count <= '0;
                r_op    <= op;
                r_dbz   <= w_req_dbz;
            end else if (w_step) begin
                r_count <= r_count + 1'b1;
            end
            if (done) r_result <= w_final;
        end
    end

    // With b == 0 the core is loaded but never stepped, so shift_x still holds a
    always_comb begin
        w_final = w_acc_rem;
        if (r_op == OP_DIV)      w_final = r_dbz ? '1 : w_shift_x;
        else if (r_op == OP_MOD) w_final = r_dbz ? w_shift_x : w_acc_rem;
    end

    assign result      = done ? w_final : r_result;
    assign div_by_zero = done && r_dbz;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .step    (w_step),
        .is_mul  (r_op == OP_MUL),
        .a       (a),
        .b       (b),
        .acc_rem (w_acc_rem),
        .shift_x (w_shift_x)
    );

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed and random checks of muldiv_sequencer vs arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] last_result = '0;

    muldiv_sequencer #(.WIDTH(WIDTH), .OP_CODE_LEN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [WIDTH-1:0] model_result(input logic [3:0] o,
                                                      input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        if (o == OP_MUL)      r = x * y;
        else if (y == '0)     r = (o == OP_DIV) ? '1 : x;
        else if (o == OP_DIV) r = x / y;
        else                  r = x % y;
        return r;
    endfunction

    // Request cycle is cycle 0; done arrives WIDTH+1 cycles later, or on the
    // very next cycle when a divide by zero skips the iterations.
    task automatic run_op(input logic [3:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input string tag);
        logic [WIDTH-1:0] exp_res;
        logic             exp_dbz;
        int               lat;
        exp_res = model_result(o, x, y);
        exp_dbz = (o != OP_MUL) && (y == '0);
        lat     = exp_dbz ? 1 : WIDTH + 1;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk({tag, " req_stall"}, stall, 1);
        chk({tag, " req_done"}, done, 0);
        for (int c = 1; c <= lat; c++) begin
            next_cycle();
            start = 1'b0; a = $urandom; b = $urandom;
            #1;
            if (c < lat) begin
                chk({tag, " busy_done"}, done, 0);
                chk({tag, " busy_stall"}, stall, 1);
            end else begin
                chk({tag, " done"}, done, 1);
                chk({tag, " result"}, result, exp_res);
                chk({tag, " dbz"}, div_by_zero, exp_dbz);
                chk({tag, " done_stall"}, stall, 0);
                chk({tag, " done_busy"}, busy, 1);
            end
        end
        last_result = exp_res;
        next_cycle();
        #1;
        chk({tag, " post_done"}, done, 0);
        chk({tag, " post_busy"}, busy, 0);
        chk({tag, " post_hold"}, result, last_result);
        chk({tag, " post_dbz"}, div_by_zero, 0);
    endtask

    initial begin
        logic [3:0]       o;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        int               sel;

        rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0; flush = 1'b0;
        #1;
        chk("reset stall", stall, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset dbz", div_by_zero, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_op(OP_MUL, 7, 6, "mul7x6");
        run_op(OP_DIV, 100, 7, "div100_7");
        run_op(OP_MOD, 100, 7, "mod100_7");
        run_op(OP_MUL, 32'hFFFF_FFFF, 2, "mul_ovf");
        run_op(OP_DIV, 5, 0, "div_zero");
        run_op(OP_MOD, 5, 0, "mod_zero");

        // Flush in the middle of a divide
        start = 1'b1; op = OP_DIV; a = 100; b = 7;
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            start = 1'b0;
            flush = (c == 10);
            #1;
        end
        flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush stall", stall, 0);
        for (int c = 12; c <= 40; c++) begin
            next_cycle();
            #1;
            chk("flush no_done", done, 0);
            chk("flush hold", result, last_result);
        end
        run_op(OP_MUL, 3, 4, "mul_after_flush");

        // A second start during BUSY and DONE must be ignored
        start = 1'b1; op = OP_DIV; a = 100; b = 7;
        for (int c = 1; c <= WIDTH + 2; c++) begin
            next_cycle();
            start = (c >= 5) && (c <= WIDTH + 1);
            op = OP_MUL; a = 2; b = 2;
            #1;
            if (c == WIDTH + 1) begin
                chk("ignore done", done, 1);
                chk("ignore result", result, 14);
            end else begin
                chk("ignore no_done", done, 0);
            end
        end
        last_result = 14;
        chk("ignore idle_busy", busy, 0);

        // Non-muldiv opcode in IDLE
        start = 1'b1; op = OP_ADD; a = 1; b = 1;
        #1;
        chk("add stall", stall, 0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            #1;
            chk("add busy", busy, 0);
            chk("add done", done, 0);
        end
        start = 1'b0;
        next_cycle();

        // Asynchronous reset mid-multiply
        start = 1'b1; op = OP_MUL; a = 9; b = 9;
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rst stall", stall, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst dbz", div_by_zero, 0);
        last_result = '0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            next_cycle();
            #1;
            chk("rst no_done", done, 0);
        end
        run_op(OP_MUL, 9, 9, "mul9x9");

        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 2);
            o   = (sel == 0) ? OP_MUL : (sel == 1) ? OP_DIV : OP_MOD;
            x   = $urandom;
            y   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
            run_op(o, x, y, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
